// File: rtl/eab_agu.sv
// -----------------------------------------------------------------------------
// eab_agu -- registered effective-address generator for the LC-3 datapath.
//
// Computes base + sext(offset field), where the base is PC or Ra and the offset
// is zero, imm11, imm9 or imm6.  The sum wraps modulo 2^WIDTH.  When built with
// EAB_INDIRECT_EN defined, a request flagged "indirect" (LDI/STI) issues one
// memory read at the computed address and returns the fetched word instead.
// Without EAB_INDIRECT_EN, the FETCH state is not built and every request is
// treated as direct.
//
// Build option:
//   EAB_INDIRECT_EN  - define to enable the indirect (memory fetch) path.
//
// Parameters:
//   WIDTH  - address/data width (>= 12)
//   IR_W   - instruction field width, ir[10:0] (11 for LC-3)
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  block can accept a request (decoded from state)
//   ir          in   instruction bits [10:0]
//   ra          in   base register value
//   pc          in   incremented PC
//   sel_base    in   1 = ra, 0 = pc
//   sel_off     in   00 zero, 01 imm11, 10 imm9, 11 imm6
//   indirect    in   resolve via memory read
//   mem_req     out  memory read request
//   mem_addr    out  memory read address
//   mem_ack     in   memory read data valid this cycle
//   mem_data    in   memory read data
//   addr_valid  out  result available
//   addr        out  resulting effective address
//   addr_ready  in   consumer accepts result
// -----------------------------------------------------------------------------
module eab_agu #(
    parameter int WIDTH = 16,
    parameter int IR_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IR_W-1:0]  ir,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] pc,
    input  logic             sel_base,
    input  logic [1:0]       sel_off,
    input  logic             indirect,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_data,
    output logic             addr_valid,
    output logic [WIDTH-1:0] addr,
    input  logic             addr_ready
);

`ifdef EAB_INDIRECT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DONE  = 2'd2
    } state_t;
`endif

    // Sign-extend the selected immediate field of ir to WIDTH bits.
    function automatic logic [WIDTH-1:0] sext_off(
        input logic [1:0]      sel,
        input logic [IR_W-1:0] f
    );
        logic [WIDTH-1:0] r;
        case (sel)
            2'b01:   r = {{(WIDTH-11){f[10]}}, f[10:0]};
            2'b10:   r = {{(WIDTH-9){f[8]}},   f[8:0]};
            2'b11:   r = {{(WIDTH-6){f[5]}},   f[5:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             addr_valid_q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] ea;

    // Address arithmetic; the sum is truncated to WIDTH so it wraps naturally.
    always_comb begin
        base = sel_base ? ra : pc;
        ea   = base + sext_off(sel_off, ir);
    end

`ifdef EAB_INDIRECT_EN
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic             mem_req_q;
`endif

    // Next-state and datapath update.  Request inputs only matter in IDLE,
    // so changes after the accept edge cannot disturb a request in flight.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
`ifdef EAB_INDIRECT_EN
        mem_addr_d = mem_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
`ifdef EAB_INDIRECT_EN
                    if (indirect) begin
                        mem_addr_d = ea;
                        state_d    = FETCH;
                    end else begin
                        addr_d  = ea;
                        state_d = DONE;
                    end
`else
                    addr_d  = ea;
                    state_d = DONE;
`endif
                end
            end
`ifdef EAB_INDIRECT_EN
            FETCH: begin
                // mem_addr is held (no update here) until the ack is seen.
                if (mem_ack) begin
                    addr_d  = mem_data;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (addr_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.  The handshake flags are registered from
    // the next state so they line up exactly with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
`ifdef EAB_INDIRECT_EN
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            addr_valid_q <= (state_d == DONE);
`ifdef EAB_INDIRECT_EN
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= (state_d == FETCH);
`endif
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign addr_valid = addr_valid_q;
    assign addr       = addr_q;

`ifdef EAB_INDIRECT_EN
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
`else
    assign mem_req  = 1'b0;
    assign mem_addr = '0;

    // Memory-side inputs and the indirect flag have no function in this build.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, indirect, mem_ack, mem_data};
`endif

endmodule

// File: tb/tb_eab_agu.sv
module tb_eab_agu;
    localparam int WIDTH = 16;
    localparam int IR_W  = 11;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [IR_W-1:0]  ir;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] pc;
    logic             sel_base;
    logic [1:0]       sel_off;
    logic             indirect;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_data;
    logic             addr_valid;
    logic [WIDTH-1:0] addr;
    logic             addr_ready;

    int checks;
    int errors;

    eab_agu #(.WIDTH(WIDTH), .IR_W(IR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ir         (ir),
        .ra         (ra),
        .pc         (pc),
        .sel_base   (sel_base),
        .sel_off    (sel_off),
        .indirect   (indirect),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .addr_valid (addr_valid),
        .addr       (addr),
        .addr_ready (addr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One direct request with immediate consumer acceptance.
    task automatic direct(input string tag, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] r,
                          input logic [IR_W-1:0] f, input logic sb, input logic [1:0] so,
                          input logic [WIDTH-1:0] exp);
        pc = p; ra = r; ir = f; sel_base = sb; sel_off = so;
        req_valid = 1'b1; addr_ready = 1'b1;
        check({tag, "_rdy_pre"}, req_ready, 1);
        tick();
        req_valid = 1'b0;
        // Input changes after accept must not matter.
        pc = 16'hAAAA; ra = 16'h5555; ir = '0;
        check({tag, "_valid"}, addr_valid, 1);
        check({tag, "_addr"}, addr, exp);
        check({tag, "_rdy_busy"}, req_ready, 0);
        tick();
        check({tag, "_valid_drop"}, addr_valid, 0);
        check({tag, "_rdy_back"}, req_ready, 1);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 1'b0; ir = '0; ra = '0; pc = '0;
        sel_base = 1'b0; sel_off = 2'b00; indirect = 1'b0;
        mem_ack = 1'b0; mem_data = '0; addr_ready = 1'b0;
        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_addr_valid", addr_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_addr", addr, 0);
        rst = 1'b0;
        tick();

        direct("pc_imm9",   16'h3000, 16'h0000, 11'h1FF, 1'b0, 2'b10, 16'h2FFF);
        direct("ra_wrap",   16'h0000, 16'hFFFF, 11'h001, 1'b1, 2'b11, 16'h0000);
        direct("ra_imm6n",  16'h0000, 16'h4000, 11'h020, 1'b1, 2'b11, 16'h3FE0);
        direct("ra_zero",   16'h0000, 16'h4000, 11'h7FF, 1'b1, 2'b00, 16'h4000);
        direct("pc_imm11n", 16'h3000, 16'h0000, 11'h400, 1'b0, 2'b01, 16'h2C00);
        direct("pc_imm11p", 16'h3000, 16'h0000, 11'h3FF, 1'b0, 2'b01, 16'h33FF);

        // Backpressure: result held, new request refused while in DONE.
        pc = 16'h1234; ir = '0; sel_base = 1'b0; sel_off = 2'b00;
        addr_ready = 1'b0; req_valid = 1'b1;
        tick();
        pc = 16'h7777; sel_off = 2'b00;   // request left asserted during DONE
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", addr_valid, 1);
            check("bp_addr", addr, 16'h1234);
            check("bp_rdy", req_ready, 0);
            tick();
        end
        addr_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("bp_rdy_back", req_ready, 1);
        check("bp_valid_drop", addr_valid, 0);
        check("bp_not_taken", addr, 16'h1234);
        tick();

        // Reset during DONE discards the result.
        pc = 16'h0100; sel_off = 2'b00; addr_ready = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rd_valid", addr_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rd_valid_clr", addr_valid, 0);
        check("rd_rdy", req_ready, 1);
        check("rd_addr", addr, 0);
        addr_ready = 1'b1;
        tick();

`ifdef EAB_INDIRECT_EN
        // Indirect: held request for 3 cycles, then ack returns the pointer.
        pc = 16'h3000; ir = 11'h005; sel_base = 1'b0; sel_off = 2'b10;
        indirect = 1'b1; req_valid = 1'b1; addr_ready = 1'b1;
        tick();
        req_valid = 1'b0; indirect = 1'b0; pc = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            check("ind_mem_req", mem_req, 1);
            check("ind_mem_addr", mem_addr, 16'h3005);
            check("ind_no_valid", addr_valid, 0);
            tick();
        end
        mem_ack = 1'b1; mem_data = 16'h5000;
        tick();
        mem_ack = 1'b0; mem_data = 16'h0000;
        check("ind_mem_req_drop", mem_req, 0);
        check("ind_valid", addr_valid, 1);
        check("ind_addr", addr, 16'h5000);
        tick();
        check("ind_rdy_back", req_ready, 1);

        // Ack in the same cycle mem_req first rises completes FETCH.
        pc = 16'h2000; ir = 11'h010; sel_off = 2'b10; indirect = 1'b1; req_valid = 1'b1;
        mem_ack = 1'b1; mem_data = 16'h0BAD;   // ignored in IDLE
        tick();
        req_valid = 1'b0; indirect = 1'b0;
        check("fast_mem_req", mem_req, 1);
        check("fast_mem_addr", mem_addr, 16'h2010);
        mem_data = 16'h6001;
        tick();
        mem_ack = 1'b0;
        check("fast_valid", addr_valid, 1);
        check("fast_addr", addr, 16'h6001);
        tick();

        // Reset two cycles into FETCH; a late ack afterwards is ignored.
        pc = 16'h3000; ir = 11'h005; sel_off = 2'b10; indirect = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; indirect = 1'b0;
        tick();
        check("rf_in_fetch", mem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rf_mem_req", mem_req, 0);
        check("rf_valid", addr_valid, 0);
        check("rf_rdy", req_ready, 1);
        mem_ack = 1'b1; mem_data = 16'h5000;
        tick();
        mem_ack = 1'b0;
        check("rf_late_ack_valid", addr_valid, 0);
        check("rf_late_ack_rdy", req_ready, 1);
        tick();
        check("rf_late_ack_valid2", addr_valid, 0);
`else
        // Indirect flag ignored: direct result after one cycle, no memory read.
        pc = 16'h3000; ir = 11'h005; sel_base = 1'b0; sel_off = 2'b10;
        indirect = 1'b1; req_valid = 1'b1; addr_ready = 1'b1;
        mem_ack = 1'b1; mem_data = 16'h5000;
        tick();
        req_valid = 1'b0; indirect = 1'b0;
        check("off_valid", addr_valid, 1);
        check("off_addr", addr, 16'h3005);
        check("off_mem_req", mem_req, 0);
        check("off_mem_addr", mem_addr, 0);
        tick();
        mem_ack = 1'b0;
        check("off_mem_req2", mem_req, 0);
        check("off_rdy_back", req_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
